// File: rtl/ram_nbank_if.sv
// Host bus of the banked RAM: access strobe, address/data, clear request and read return.
// Read data is carried on 'dout' because 'do' is a reserved word.
interface ram_nbank_if #(
    parameter int AW = 13,
    parameter int DW = 8
);
    logic          ce;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] di;
    logic          clr;
    logic [DW-1:0] dout;
    logic          rvalid;
    logic          err;
    logic          busy;

    modport master (
        output ce, we, addr, di, clr,
        input  dout, rvalid, err, busy
    );

    modport slave (
        input  ce, we, addr, di, clr,
        output dout, rvalid, err, busy
    );
endinterface

// File: rtl/ram_nbank.sv
// NBANK single-port RAM banks behind one flat address space, with a zero-fill sequencer.
// Define RAM_NBANK_OREG_EN to add an output register (read latency 2 instead of 1).
module ram_nbank #(
    parameter int DW    = 8,
    parameter int BAW   = 11,
    parameter int NBANK = 3,
    parameter int AW    = 13
) (
    input  logic        clk,
    input  logic        rst,
    ram_nbank_if.slave  bus
);

    localparam int BW  = AW - BAW;
    localparam int CBW = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int CW  = BAW + CBW;
    localparam logic [CW-1:0] LAST_WORD = CW'(NBANK * (2 ** BAW) - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            init_req;
    logic [CW-1:0]   clr_cnt;
    logic [CBW-1:0]  clr_bank;
    logic [BAW-1:0]  clr_off;
    logic            busy;
    logic            clr_en;

    logic [BW-1:0]   bank_idx;
    logic [BAW-1:0]  offset;
    logic            in_range;
    logic            acc;
    logic            acc_rd;

    logic            p1_valid;
    logic            p1_err;
    logic            p1_zero;
    logic [BW-1:0]   p1_bank;
    logic [DW-1:0]   dout1;
    logic [DW-1:0]   rd_all [NBANK];

    assign bank_idx = bus.addr[AW-1:BAW];
    assign offset   = bus.addr[BAW-1:0];
    assign in_range = 32'(bank_idx) < NBANK;
    assign acc      = bus.ce & ~busy & ~rst;
    assign acc_rd   = acc & ~bus.we;
    assign clr_bank = clr_cnt[CW-1:BAW];
    assign clr_off  = clr_cnt[BAW-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        clr_en   = 1'b0;
        unique case (state)
            IDLE: begin
                if (init_req || bus.clr) state_nx = CLEAR;
            end
            CLEAR: begin
                busy   = 1'b1;
                clr_en = 1'b1;
                if (clr_cnt == LAST_WORD) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Holds a fill request across reset so the first cycle after release starts CLEAR.
    always_ff @(posedge clk) begin
        if (rst) init_req <= 1'b1;
        else     init_req <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            clr_cnt <= '0;
        else if (clr_en)
            clr_cnt <= (clr_cnt == LAST_WORD) ? '0 : clr_cnt + CW'(1);
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        // NOTE: the storage array has no reset; zeroing is done by the CLEAR sequence instead.
        logic [DW-1:0]  mem [2**BAW];
        logic [DW-1:0]  rd_q;
        logic           we_b;
        logic           re_b;
        logic [BAW-1:0] waddr;
        logic [DW-1:0]  wdata;

        assign we_b  = clr_en ? (clr_bank == CBW'(b))
                              : (acc & bus.we & in_range & (bank_idx == BW'(b)));
        assign re_b  = acc_rd & in_range & (bank_idx == BW'(b));
        assign waddr = clr_en ? clr_off : offset;
        assign wdata = clr_en ? '0 : bus.di;

        always_ff @(posedge clk) begin
            if (we_b) mem[waddr] <= wdata;
            if (re_b) rd_q <= mem[offset];
        end

        assign rd_all[b] = rd_q;
    end

    // Bank select and zero flag only move on a read, so the muxed data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid <= 1'b0;
            p1_err   <= 1'b0;
            p1_zero  <= 1'b1;
            p1_bank  <= '0;
        end else begin
            p1_valid <= acc_rd;
            p1_err   <= acc & ~in_range;
            if (acc_rd) begin
                p1_bank <= bank_idx;
                p1_zero <= ~in_range;
            end
        end
    end

    assign dout1 = p1_zero ? '0 : rd_all[p1_bank];

`ifdef RAM_NBANK_OREG_EN
    logic [DW-1:0] dout_q;
    logic          rvalid_q;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q   <= '0;
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            dout_q   <= dout1;
            rvalid_q <= p1_valid;
            err_q    <= p1_err;
        end
    end

    assign bus.dout   = dout_q;
    assign bus.rvalid = rvalid_q;
    assign bus.err    = err_q;
`else
    assign bus.dout   = dout1;
    assign bus.rvalid = p1_valid;
    assign bus.err    = p1_err;
`endif

    assign bus.busy = busy;

endmodule

// File: tb/tb_ram_nbank.sv
// Directed bench for ram_nbank: reference memory model plus a queue of expected read/err returns.
module tb_ram_nbank;

`ifdef RAM_NBANK_OREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif
    localparam int WORDS = 6144;

    typedef struct {
        int         due;
        logic       rv;
        logic       er;
        logic [7:0] d;
    } exp_t;

    logic clk;
    logic rst;

    ram_nbank_if #(.AW(13), .DW(8)) bus ();

    ram_nbank dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t       sbq [$];
    logic [7:0] model [0:WORDS-1];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic       mbusy    = 1'b0;
    logic [7:0] last_do  = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s @cycle %0d: observed=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock edge, then compare outputs against the scoreboard head or the idle/hold expectation.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("rvalid", 32'(bus.rvalid), 32'(e.rv));
            chk("err", 32'(bus.err), 32'(e.er));
            if (e.rv) last_do = e.d;
            chk("do", 32'(bus.dout), 32'(last_do));
        end else begin
            chk("idle_rvalid", 32'(bus.rvalid), 32'd0);
            chk("idle_err", 32'(bus.err), 32'd0);
            chk("hold_do", 32'(bus.dout), 32'(last_do));
        end
    endtask

    task automatic step(input logic c, input logic w, input logic [12:0] a,
                        input logic [7:0] d, input logic cl);
        exp_t e;
        logic acc;
        logic inr;
        logic start;
        @(negedge clk);
        bus.ce   = c;
        bus.we   = w;
        bus.addr = a;
        bus.di   = d;
        bus.clr  = cl;
        acc   = c && !mbusy;
        inr   = (a < 13'd6144);
        start = cl && !mbusy;
        if (acc && (!w || !inr)) begin
            e.due = cyc + L;
            e.rv  = !w;
            e.er  = !inr;
            e.d   = (!w && inr) ? model[a] : 8'h00;
            sbq.push_back(e);
        end
        if (acc && w && inr) model[a] = d;
        tick();
        bus.ce  = 1'b0;
        bus.we  = 1'b0;
        bus.clr = 1'b0;
        if (start) begin
            mbusy = 1'b1;
            foreach (model[i]) model[i] = 8'h00;
        end
    endtask

    task automatic rd(input logic [12:0] a);
        step(1'b1, 1'b0, a, 8'h00, 1'b0);
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        step(1'b1, 1'b1, a, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 13'h0, 8'h00, 1'b0);
    endtask

    // Counts remaining busy cycles from the current sample point, bounded.
    task automatic wait_clear(input int exp_n, input string tag);
        int n;
        n = 0;
        chk({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        while (bus.busy === 1'b1 && n < 10000) begin
            tick();
            n++;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
        mbusy = 1'b0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst     = 1'b1;
        bus.ce  = 1'b0;
        bus.we  = 1'b0;
        bus.clr = 1'b0;
        sbq.delete();
        last_do = 8'h00;
        mbusy   = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("rst_busy", 32'(bus.busy), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        mbusy = 1'b1;
        foreach (model[i]) model[i] = 8'h00;
    endtask

    initial begin
        rst      = 1'b1;
        bus.ce   = 1'b0;
        bus.we   = 1'b0;
        bus.addr = '0;
        bus.di   = '0;
        bus.clr  = 1'b0;

        // Power-up: reset values, then the automatic zero fill.
        do_reset(3);
        wait_clear(WORDS, "init");
        rd(13'h0000);
        rd(13'h07FF);
        rd(13'h0801);
        rd(13'h17FF);
        idle(3);

        // Write then read-after-write, do holds afterwards.
        wr(13'h0801, 8'hA5);
        rd(13'h0801);
        idle(3);

        // Out-of-range read and write; all banks at offset 0x100 stay untouched.
        rd(13'h1800);
        wr(13'h1900, 8'h5A);
        rd(13'h0100);
        rd(13'h0900);
        rd(13'h1100);
        idle(2);

        // Back-to-back reads across the three banks.
        wr(13'h0000, 8'h11);
        wr(13'h0800, 8'h22);
        wr(13'h1000, 8'h33);
        rd(13'h0000);
        rd(13'h0800);
        rd(13'h1000);
        idle(3);

        // Last word of the last bank and last word of bank 0.
        wr(13'h17FF, 8'h5C);
        rd(13'h17FF);
        wr(13'h07FF, 8'h3C);
        rd(13'h07FF);
        idle(2);

        // Read accepted in the same cycle as clr completes with old data, then the fill runs.
        step(1'b1, 1'b0, 13'h0801, 8'h00, 1'b1);
        wait_clear(WORDS, "clr_rd");
        rd(13'h0801);
        rd(13'h1000);
        idle(2);

        // Accesses and a second clr during busy are ignored.
        step(1'b0, 1'b0, 13'h0000, 8'h00, 1'b1);
        wr(13'h0010, 8'hFF);
        step(1'b1, 1'b0, 13'h0801, 8'h00, 1'b1);
        wait_clear(WORDS - 2, "clr_busy");
        rd(13'h0010);
        idle(2);

        // Reset in the middle of a fill restarts it from word 0.
        wr(13'h0005, 8'h99);
        step(1'b0, 1'b0, 13'h0000, 8'h00, 1'b1);
        for (int i = 0; i < 2999; i++) tick();
        chk("mid_clear_busy", 32'(bus.busy), 32'd1);
        do_reset(2);
        wait_clear(WORDS, "rst_abort");
        rd(13'h0005);
        rd(13'h0801);
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
